fetch_controller: RTL

Instruction-fetch sequencer between the program counter / instruction memory datapath and the decode stage. Owns the fetch PC, issues one-outstanding read requests to instruction memory, and buffers returned instructions in a small FIFO with a valid/ready handshake toward decode. Handles branch redirects, including flushing buffered instructions and discarding an in-flight response. Supports memories with any response latency of one cycle or more.

---
 rtl/fetch_controller_if.sv | 24 ++
 rtl/fetch_controller.sv | 103 ++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
// Handshake bundle between the fetch sequencer, instruction memory and decode.
// The master view belongs to fetch_controller; the slave view to its environment.
interface fetch_controller_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  modport master (
    input  redirect_valid, redirect_target, imem_rvalid, imem_rdata, id_ready,
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output redirect_valid, redirect_target, imem_rvalid, imem_rdata, id_ready,
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: one outstanding imem read, a DEPTH-entry {pc, instr}
// buffer toward decode, and redirect handling that flushes and drops stale responses.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input logic                clk,
  input logic                rst_n,
  fetch_controller_if.master bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [31:0]      fetch_pc, req_pc;
  logic [31:0]      buf_pc    [DEPTH];
  logic [31:0]      buf_instr [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             issue, push, pop, flush, has_room;
  logic [31:0]      target;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign target   = {bus.redirect_target[31:2], 2'b00};
  assign has_room = count < CNT_W'(DEPTH);
  assign flush    = bus.redirect_valid;
  assign pop      = bus.if_valid && bus.id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!bus.redirect_valid && has_room) state_nxt = WAIT;
      WAIT: begin
        if (bus.imem_rvalid)         state_nxt = IDLE;
        else if (bus.redirect_valid) state_nxt = FLUSH;
      end
      FLUSH:   if (bus.imem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    unique case (state)
      IDLE:    issue = !bus.redirect_valid && has_room;
      WAIT:    push  = bus.imem_rvalid && !bus.redirect_valid;
      default: ;
    endcase
  end

  // The request is a Mealy output of IDLE; it is masked while reset is held so
  // no request leaks out before the first post-reset cycle.
  assign bus.imem_req  = issue && rst_n;
  assign bus.imem_addr = bus.imem_req ? fetch_pc : req_pc;
  assign bus.if_valid  = (count != '0) && !bus.redirect_valid;
  assign bus.if_pc     = buf_pc[head];
  assign bus.if_instr  = buf_instr[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else begin
      if (flush)     fetch_pc <= target;
      else if (push) fetch_pc <= fetch_pc + 32'd4;

      if (issue) req_pc <= fetch_pc;

      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) begin
          buf_pc[tail]    <= req_pc;
          buf_instr[tail] <= bus.imem_rdata;
          tail            <= ptr_inc(tail);
        end
        if (pop) head <= ptr_inc(head);
        if (push && !pop)      count <= count + CNT_W'(1);
        else if (pop && !push) count <= count - CNT_W'(1);
      end
    end
  end
endmodule
